dcpu16_mem_rsp: RTL

//   Bus responder (slave) for the DCPU16 memory port protocol (stb/wre/adr/dat/ack).

---
 rtl/dcpu16_mem_rsp.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dcpu16_mem_rsp.sv
// dcpu16_mem_rsp: memory-side responder for the DCPU16 stb/wre/adr/dat/ack
// port. Holds a 2**AW x DW word RAM and answers each request after a fixed
// number of wait states, so the CPU can be run against slow memory.
//
// Handshake: the initiator raises stb with wre/adr/dti valid and holds them
// until ack. The request is accepted on the first edge that sees stb in IDLE.
// ack is a one-cycle pulse. A read's data appears on dto in the same cycle as
// ack and stays there until the next read completes. Dropping stb before ack
// aborts the transfer with no side effects. stb seen in the ACK cycle is
// ignored, so a continuously held stb yields one transfer per WAIT+2 cycles.
module dcpu16_mem_rsp #(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int WAIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stb,
    input  logic          wre,
    input  logic [15:0]   adr,
    input  logic [DW-1:0] dti,
    output logic [DW-1:0] dto,
    output logic          ack
);

    // Wait counter start value; counts down to zero inside the WAIT state.
    localparam logic [3:0] CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    // FSM state is kept as a named enum register so it can be probed directly.
    state_t           state_q;
    state_t           state_n;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_n;

    // Request fields captured at accept.
    logic             lat_wre;
    logic [AW-1:0]    lat_adr;
    logic [DW-1:0]    lat_dat;

    logic             accept;
    logic             commit;

    // Fields used by the commit; with WAIT=0 accept and commit share an edge,
    // so the live inputs are used instead of the (not yet loaded) latches.
    logic             cmt_wre;
    logic [AW-1:0]    cmt_adr;
    logic [DW-1:0]    cmt_dat;

    logic [DW-1:0]    bram [0:(1 << AW) - 1];
    logic [DW-1:0]    dto_q;

    // Next-state, wait counter and accept/commit strobes.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (stb) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        state_n = S_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!stb) begin
                    state_n = S_IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_n = S_ACK;
                    commit  = 1'b1;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Select latched or live request fields for the commit edge.
    always_comb begin
        cmt_wre = lat_wre;
        cmt_adr = lat_adr;
        cmt_dat = lat_dat;
        if (accept) begin
            cmt_wre = wre;
            cmt_adr = adr[AW-1:0];
            cmt_dat = dti;
        end
    end

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Capture the request on accept; later changes on the bus are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_wre <= 1'b0;
            lat_adr <= '0;
            lat_dat <= '0;
        end else if (accept) begin
            lat_wre <= wre;
            lat_adr <= adr[AW-1:0];
            lat_dat <= dti;
        end
    end

    // RAM write on the edge entering ACK; never while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && commit && cmt_wre) begin
            bram[cmt_adr] <= cmt_dat;
        end
    end

    // Registered read on the edge entering ACK; held until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            dto_q <= '0;
        end else if (commit && !cmt_wre) begin
            dto_q <= bram[cmt_adr];
        end
    end

    assign ack = (state_q == S_ACK);
    assign dto = dto_q;

endmodule
